// File: rtl/avalon_ocram_param.sv
// Avalon-MM on-chip RAM slave with optional zero-fill after reset and 1- or 2-cycle read latency.
// States: ST_INIT = zero-fill in progress (or a one-cycle pass when the fill is disabled) | ST_READY = serving accesses.
module avalon_ocram_param #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 13,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("avalon_ocram_param: DATA_WIDTH must be a multiple of 8 and at least 8");
  end
  if (ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("avalon_ocram_param: ADDR_WIDTH must be at least 1");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("avalon_ocram_param: READ_LATENCY must be 1 or 2");
  end
  if (CLEAR_ON_RESET != 0 && CLEAR_ON_RESET != 1) begin : g_bad_clear
    $error("avalon_ocram_param: CLEAR_ON_RESET must be 0 or 1");
  end

  typedef enum logic {ST_INIT, ST_READY} state_t;

  // Extra counter bit lets the fill detect completion without wrapping to 0.
  localparam logic [ADDR_WIDTH:0] CNT_DONE = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  clr_en;
  logic                  wr_acc, rd_acc;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd1_data_q;
  logic                  rd1_vld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (CLEAR_ON_RESET == 0 || cnt_q == CNT_DONE) begin
          state_d = ST_READY;
        end else begin
          clr_en = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  assign init_done   = (state_q == ST_READY);
  assign waitrequest = (state_q != ST_READY) | ~clken;
  assign wr_acc      = chipselect & write & ~waitrequest;
  assign rd_acc      = chipselect & read & ~waitrequest & ~write;

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

  // First read stage only loads on accept, so data holds between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd1_data_q <= '0;
      rd1_vld_q  <= 1'b0;
    end else begin
      rd1_vld_q <= rd_acc;
      if (rd_acc) rd1_data_q <= mem[address];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd2_data_q;
    logic                  rd2_vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd2_data_q <= '0;
        rd2_vld_q  <= 1'b0;
      end else begin
        rd2_vld_q <= rd1_vld_q;
        if (rd1_vld_q) rd2_data_q <= rd1_data_q;
      end
    end

    assign readdata      = rd2_data_q;
    assign readdatavalid = rd2_vld_q;
  end else begin : g_lat1
    assign readdata      = rd1_data_q;
    assign readdatavalid = rd1_vld_q;
  end

endmodule

// File: tb/tb_avalon_ocram_param.sv
// Directed bench: instance A uses defaults, instance B is a 16-word, latency-2, no-fill RAM.
module tb_avalon_ocram_param;

  logic        clk;
  logic        reset_n;

  logic [12:0] a_addr;
  logic [1:0]  a_be;
  logic        a_cs, a_rd, a_wr, a_clken;
  logic [15:0] a_wdata, a_rdata;
  logic        a_rdv, a_wait, a_done;

  logic [3:0]  b_addr;
  logic [1:0]  b_be;
  logic        b_cs, b_rd, b_wr, b_clken;
  logic [15:0] b_wdata, b_rdata;
  logic        b_rdv, b_wait, b_done;

  int n_cmp = 0;
  int n_err = 0;

  avalon_ocram_param u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(a_addr), .byteenable(a_be),
    .chipselect(a_cs), .read(a_rd), .write(a_wr), .writedata(a_wdata),
    .clken(a_clken), .readdata(a_rdata), .readdatavalid(a_rdv),
    .waitrequest(a_wait), .init_done(a_done)
  );

  avalon_ocram_param #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(0)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(b_addr), .byteenable(b_be),
    .chipselect(b_cs), .read(b_rd), .write(b_wr), .writedata(b_wdata),
    .clken(b_clken), .readdata(b_rdata), .readdatavalid(b_rdv),
    .waitrequest(b_wait), .init_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [12:0] addr, input logic [15:0] data, input logic [1:0] be);
    a_addr = addr; a_wdata = data; a_be = be; a_cs = 1'b1; a_wr = 1'b1;
    tick();
    a_cs = 1'b0; a_wr = 1'b0;
    chk("a_wr_no_rdv", a_rdv, 0);
  endtask

  task automatic a_read(input logic [12:0] addr, input logic [15:0] exp, input string tag);
    a_addr = addr; a_cs = 1'b1; a_rd = 1'b1;
    tick();
    a_cs = 1'b0; a_rd = 1'b0;
    chk({tag, "_rdv"}, a_rdv, 1);
    chk({tag, "_data"}, a_rdata, exp);
    tick();
    chk({tag, "_pulse"}, a_rdv, 0);
  endtask

  task automatic b_write(input logic [3:0] addr, input logic [15:0] data);
    b_addr = addr; b_wdata = data; b_be = 2'b11; b_cs = 1'b1; b_wr = 1'b1;
    tick();
    b_cs = 1'b0; b_wr = 1'b0;
  endtask

  task automatic a_wait_init(input string tag);
    logic early;
    early = 1'b0;
    for (int i = 1; i <= 8192; i++) begin
      tick();
      if (a_done || !a_wait) early = 1'b1;
    end
    chk({tag, "_no_early_done"}, early, 0);
    tick();
    chk({tag, "_done"}, a_done, 1);
    chk({tag, "_wait_low"}, a_wait, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    a_addr = '0; a_be = '0; a_cs = 0; a_rd = 0; a_wr = 0; a_wdata = '0; a_clken = 1'b1;
    b_addr = '0; b_be = '0; b_cs = 0; b_rd = 0; b_wr = 0; b_wdata = '0; b_clken = 1'b1;

    repeat (3) tick();
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_a_rdv", a_rdv, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_wait", a_wait, 1);
    chk("rst_b_done", b_done, 0);
    chk("rst_b_wait", b_wait, 1);

    // Release, then reset again at INIT cycle 100.
    reset_n = 1'b1;
    tick();
    chk("b_ready_first_edge", b_done, 1);
    chk("a_init_after_1", a_done, 0);
    repeat (99) tick();
    chk("a_init_100_wait", a_wait, 1);
    reset_n = 1'b0;
    #1;
    chk("midinit_rst_done", a_done, 0);
    chk("midinit_rst_wait", a_wait, 1);
    chk("midinit_rst_rdv", a_rdv, 0);
    chk("midinit_rst_rdata", a_rdata, 0);
    chk("midinit_rst_b_done", b_done, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    a_wait_init("init1");

    a_read(13'h1FFF, 16'h0000, "rd_top");
    a_read(13'h0000, 16'h0000, "rd_zero");

    a_write(13'h0010, 16'hA5C3, 2'b11);
    a_read(13'h0010, 16'hA5C3, "rd_full");
    a_write(13'h0010, 16'h1234, 2'b01);
    a_read(13'h0010, 16'hA534, "rd_lo_lane");
    a_write(13'h0010, 16'hFF00, 2'b10);
    a_read(13'h0010, 16'hFF34, "rd_hi_lane");

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) a_write(13'h0030 + 13'(i), 16'h0A00 + 16'(i), 2'b11);
    a_addr = 13'h0030; a_cs = 1'b1; a_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b_rdv", a_rdv, 1);
      chk("b2b_data", a_rdata, 32'h0A00 + 32'(i));
      if (i < 3) a_addr = 13'h0031 + 13'(i);
      else begin a_cs = 1'b0; a_rd = 1'b0; end
    end
    tick();
    chk("b2b_end_rdv", a_rdv, 0);

    // clken low stalls new reads but the read accepted just before still returns.
    a_addr = 13'h0010; a_cs = 1'b1; a_rd = 1'b1;
    tick();
    a_clken = 1'b0; a_addr = 13'h0020;
    #1;
    chk("clken_wait", a_wait, 1);
    chk("clken_prev_rdv", a_rdv, 1);
    chk("clken_prev_data", a_rdata, 16'hFF34);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("clken_no_rdv", a_rdv, 0);
      chk("clken_wait_held", a_wait, 1);
    end
    chk("rdata_hold", a_rdata, 16'hFF34);
    a_cs = 1'b0; a_rd = 1'b0; a_clken = 1'b1;
    tick();

    // Simultaneous read and write: write wins, no response.
    a_addr = 13'h0020; a_wdata = 16'hBEEF; a_be = 2'b11;
    a_cs = 1'b1; a_rd = 1'b1; a_wr = 1'b1;
    tick();
    a_cs = 1'b0; a_rd = 1'b0; a_wr = 1'b0;
    chk("rw_no_rdv0", a_rdv, 0);
    tick();
    chk("rw_no_rdv1", a_rdv, 0);
    a_read(13'h0020, 16'hBEEF, "rd_after_rw");

    // Latency-2 instance: four consecutive reads.
    for (int i = 0; i < 4; i++) b_write(4'(i), 16'(i + 1));
    b_addr = 4'h0; b_cs = 1'b1; b_rd = 1'b1;
    tick();
    chk("l2_no_rdv_after_1", b_rdv, 0);
    b_addr = 4'h1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("l2_rdv", b_rdv, 1);
      chk("l2_data", b_rdata, 32'(i + 1));
      if (i < 2) b_addr = 4'(i + 2);
      else begin b_cs = 1'b0; b_rd = 1'b0; end
    end
    tick();
    chk("l2_end_rdv", b_rdv, 0);
    chk("l2_hold", b_rdata, 16'h0004);

    // Reset in READY: in-flight read discarded, fill really rewrites RAM.
    a_write(13'h1FFF, 16'hDEAD, 2'b11);
    a_write(13'h0000, 16'h5555, 2'b11);
    a_read(13'h1FFF, 16'hDEAD, "rd_pre_refill");
    b_addr = 4'h2; b_cs = 1'b1; b_rd = 1'b1;
    tick();
    b_cs = 1'b0; b_rd = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("inflight_rst_rdv", b_rdv, 0);
    chk("inflight_rst_rdata", b_rdata, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("inflight_discarded", b_rdv, 0);
    end
    // Four of the 8192 fill edges already elapsed above.
    for (int i = 0; i < 8188; i++) tick();
    chk("refill_not_done", a_done, 0);
    tick();
    chk("refill_done", a_done, 1);
    a_read(13'h1FFF, 16'h0000, "rd_refill_top");
    a_read(13'h0000, 16'h0000, "rd_refill_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
